// File: rtl/lavagem_display_scan.sv
// Multiplexed seven-segment scanner showing the held washing-stage code as a two-glyph pair.
// Optional post-change blink is compiled in with LAVAGEM_BLINK_EN.
module lavagem_display_scan #(
  parameter int NUM_DIGITS   = 2,
  parameter int SCAN_DIV     = 50000,
  parameter int BLINK_FRAMES = 8
) (
  input  logic                  i_clock,
  input  logic                  i_reset,
  input  logic                  i_load,
  input  logic [2:0]            i_stage,
  input  logic                  i_en,
  output logic [6:0]            o_seg_n,
  output logic [NUM_DIGITS-1:0] o_dig_n
);

  localparam int CW = $clog2(SCAN_DIV);
  localparam int DW = $clog2(NUM_DIGITS);
  localparam logic [CW-1:0] CNT_LAST = CW'(SCAN_DIV - 1);
  localparam logic [DW-1:0] DIG_LAST = DW'(NUM_DIGITS - 1);

  if (NUM_DIGITS < 2 || NUM_DIGITS > 8 || SCAN_DIV < 2 ||
      BLINK_FRAMES < 1 || BLINK_FRAMES > 255) begin : g_bad_params
    $error("lavagem_display_scan: parameter out of range");
  end

  logic [2:0]    r_stage;
  logic [CW-1:0] r_cnt;
  logic [DW-1:0] r_dig;
  logic [6:0]    r_seg_n;
  logic [NUM_DIGITS-1:0] r_dig_n;
  logic          w_frame_end, w_restart, w_blank;
  logic [6:0]    w_seg;

  function automatic logic [6:0] glyph_right(input logic [2:0] s);
    case (s)
      3'd0:    return 7'b0001001;
      3'd1:    return 7'b0100100;
      3'd2:    return 7'b0110000;
      3'd3:    return 7'b1101010;
      3'd4:    return 7'b0011000;
      3'd5:    return 7'b1001111;
      3'd6:    return 7'b0010010;
      default: return 7'b1100010;
    endcase
  endfunction

  function automatic logic [6:0] glyph_left(input logic [2:0] s);
    case (s)
      3'd0:                return 7'b0001001;
      3'd1:                return 7'b0100100;
      3'd2, 3'd3, 3'd4:    return 7'b1110001;
      default:             return 7'b0110000;
    endcase
  endfunction

  assign w_frame_end = (r_cnt == CNT_LAST) && (r_dig == DIG_LAST);
  // Re-loading the stage already shown is a no-op; only a real change restarts the scan.
  assign w_restart   = i_load && (i_stage != r_stage);

  always_ff @(posedge i_clock or posedge i_reset) begin
    if (i_reset) begin
      r_stage <= 3'd0;
      r_cnt   <= '0;
      r_dig   <= '0;
    end else begin
      if (w_restart) begin
        r_stage <= i_stage;
        r_cnt   <= '0;
        r_dig   <= '0;
      end else if (r_cnt == CNT_LAST) begin
        r_cnt <= '0;
        r_dig <= (r_dig == DIG_LAST) ? '0 : r_dig + 1'b1;
      end else begin
        r_cnt <= r_cnt + 1'b1;
      end
    end
  end

`ifdef LAVAGEM_BLINK_EN
  logic [7:0] r_blink_cnt;
  logic       r_phase;

  // Restart takes priority over frame end, so a re-arm always begins on a fresh blank frame.
  always_ff @(posedge i_clock or posedge i_reset) begin
    if (i_reset) begin
      r_blink_cnt <= 8'd0;
      r_phase     <= 1'b0;
    end else if (w_restart) begin
      r_blink_cnt <= 8'(BLINK_FRAMES);
      r_phase     <= 1'b1;
    end else if (w_frame_end && r_blink_cnt != 8'd0) begin
      r_blink_cnt <= r_blink_cnt - 8'd1;
      r_phase     <= ~r_phase;
    end
  end

  assign w_blank = r_phase && (r_blink_cnt != 8'd0);
`else
  assign w_blank = 1'b0;
`endif

  always_comb begin
    w_seg = 7'b1111111;
    if (r_dig == DW'(0))      w_seg = glyph_right(r_stage);
    else if (r_dig == DW'(1)) w_seg = glyph_left(r_stage);
    if (w_blank) w_seg = 7'b1111111;
  end

  always_ff @(posedge i_clock or posedge i_reset) begin
    if (i_reset) begin
      r_seg_n <= 7'b1111111;
      r_dig_n <= '1;
    end else if (i_en) begin
      r_seg_n <= w_seg;
      r_dig_n <= ~(NUM_DIGITS'(1) << r_dig);
    end else begin
      r_seg_n <= 7'b1111111;
      r_dig_n <= '1;
    end
  end

  assign o_seg_n = r_seg_n;
  assign o_dig_n = r_dig_n;

endmodule

// File: tb/tb_lavagem_display_scan.sv
// Randomized scoreboard bench for lavagem_display_scan (4 digits, 4-cycle dwell, 2 blink frames).
module tb_lavagem_display_scan;
  localparam int ND = 4, SD = 4, BF = 2, FRAME = ND * SD;

  logic          clk = 1'b0;
  logic          rst, load, en;
  logic [2:0]    stage;
  logic [6:0]    seg_n;
  logic [ND-1:0] dig_n;

  lavagem_display_scan #(.NUM_DIGITS(ND), .SCAN_DIV(SD), .BLINK_FRAMES(BF)) dut (
    .i_clock(clk), .i_reset(rst), .i_load(load), .i_stage(stage), .i_en(en),
    .o_seg_n(seg_n), .o_dig_n(dig_n)
  );

  always #5 clk = ~clk;

  localparam logic [6:0] RGT [8] = '{7'b0001001, 7'b0100100, 7'b0110000, 7'b1101010,
                                     7'b0011000, 7'b1001111, 7'b0010010, 7'b1100010};
  localparam logic [6:0] LFT [8] = '{7'b0001001, 7'b0100100, 7'b1110001, 7'b1110001,
                                     7'b1110001, 7'b0110000, 7'b0110000, 7'b0110000};

  typedef struct packed { logic [6:0] seg; logic [ND-1:0] dig; } exp_t;
  exp_t q[$];
  int n_chk = 0, n_fail = 0;
  bit started = 1'b0;

  // Reference state: cycles since the last scan restart, the shown stage, blink armed.
  int       pos;
  logic [2:0] stq;
  bit       armed;

  function automatic exp_t expect_out(bit en_v);
    exp_t e;
    int   d, f;
    e.seg = 7'b1111111;
    e.dig = '1;
    if (!en_v) return e;
    d = (pos / SD) % ND;
    f = pos / FRAME;
    e.dig = '1;
    e.dig[d] = 1'b0;
    if (d == 0) e.seg = RGT[stq];
    else if (d == 1) e.seg = LFT[stq];
    if (armed && f < BF && (f % 2) == 0) e.seg = 7'b1111111;
    return e;
  endfunction

  task automatic check(string name, exp_t e);
    n_chk++;
    if (seg_n !== e.seg || dig_n !== e.dig) begin
      n_fail++;
      $display("FAIL %s @%0t: seg_n=%b dig_n=%b, expected seg_n=%b dig_n=%b",
               name, $time, seg_n, dig_n, e.seg, e.dig);
    end
  endtask

  task automatic model_reset();
    pos = 0; stq = 3'd0; armed = 1'b0;
  endtask

  // One clock of stimulus: drive at negedge, push what the next posedge must produce.
  task automatic step(bit r, bit ld, logic [2:0] st, bit e_in);
    exp_t ones;
    ones.seg = 7'b1111111;
    ones.dig = '1;
    @(negedge clk);
    load = ld; stage = st; en = e_in;
    started = 1'b1;
    if (r) begin
      rst = 1'b1;
      #1;
      check("reset_immediate", ones);
      model_reset();
      q.push_back(ones);
    end else begin
      rst = 1'b0;
      q.push_back(expect_out(e_in));
      if (ld && st != stq) begin
        stq = st;
        pos = 0;
`ifdef LAVAGEM_BLINK_EN
        armed = 1'b1;
`endif
      end else begin
        pos++;
      end
    end
  endtask

  initial begin : monitor
    exp_t e;
    forever begin
      @(posedge clk);
      #1;
      if (started) begin
        if (q.size() == 0) begin
          n_chk++; n_fail++;
          $display("FAIL scoreboard_empty @%0t: output seen, no expectation queued", $time);
        end else begin
          e = q.pop_front();
          check("scan_out", e);
        end
      end
    end
  end

  initial begin : stim
    exp_t ones;
    bit busy, ld, e_in, r;
    logic [2:0] st;
    int en_off;
    ones.seg = 7'b1111111;
    ones.dig = '1;
    rst = 1'b1; load = 1'b0; stage = 3'd0; en = 1'b1;
    model_reset();
    #1;
    check("reset_state", ones);
    step(1, 0, 3'd0, 1);
    step(1, 0, 3'd0, 1);
    for (int i = 0; i < 40; i++) step(0, 0, 3'd0, 1);
    step(0, 1, 3'd3, 1);
    for (int i = 0; i < 40; i++) step(0, 0, 3'd0, 1);
    en_off = 0;
    for (int i = 0; i < 3000; i++) begin
      busy = ((i / 400) % 2) == 1;
      ld   = $urandom_range(0, busy ? 3 : 45) == 0;
      st   = ($urandom_range(0, 2) == 0) ? stq : 3'($urandom_range(0, 7));
      if (en_off == 0 && $urandom_range(0, 60) == 0) en_off = 10;
      e_in = (en_off == 0);
      if (en_off > 0) en_off--;
      r = $urandom_range(0, 350) == 0;
      step(r, ld, st, e_in);
    end
    @(posedge clk);
    #2;
    started = 1'b0;
    n_chk++;
    if (q.size() != 0) begin
      n_fail++;
      $display("FAIL scoreboard_drain: %0d expectations left, expected 0", q.size());
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/lavagem_display_scan.md
LAVAGEM_DISPLAY_SCAN -- requirements
Module: lavagem_display_scan

Interface
REQ-001 Parameter NUM_DIGITS, default 2: number of multiplexed seven-segment digits, legal range 2..8.
REQ-002 Parameter SCAN_DIV, default 50000: clock cycles each digit stays active, legal range >= 2.
REQ-003 Parameter BLINK_FRAMES, default 8: scan frames of blinking after a stage change, legal range 1..255.
REQ-004 clock  input  1  single system clock; all state changes on its rising edge.
REQ-005 reset  input  1  asynchronous, active-high reset.
REQ-006 load  input  1  when high at a rising edge, stage is captured.
REQ-007 stage  input  3  washing stage code, 0..7.
REQ-008 en  input  1  display enable; low blanks all outputs.
REQ-009 seg_n  output  7  active-low segments, bit 6 = a, bit 0 = g, registered.
REQ-010 dig_n  output  NUM_DIGITS  active-low digit selects, bit 0 = rightmost digit, registered.

Function
REQ-011 Held stage register stage_q SHALL load stage on every rising edge with load high.
REQ-012 Glyph table, left|right, 7 bits each, SHALL be:
- 0: 0001001|0001001, 1: 0100100|0100100, 2: 1110001|0110000, 3: 1110001|1101010
- 4: 1110001|0011000, 5: 0110000|1001111, 6: 0110000|0010010, 7: 0110000|1100010.
REQ-013 Digit 0 SHALL show the right glyph of stage_q, digit 1 the left glyph, digits 2..NUM_DIGITS-1 blank (1111111).
REQ-014 Scan counter SHALL count 0..SCAN_DIV-1 and wrap; on wrap, digit index SHALL advance by 1, wrapping NUM_DIGITS-1 -> 0.
REQ-015 dig_n SHALL have exactly one bit low (the current digit index) while en is high.
REQ-016 Frame end SHALL be defined as scan counter = SCAN_DIV-1 and digit index = NUM_DIGITS-1.
REQ-017 seg_n/dig_n SHALL reflect state registered at edge N from edge N+1 (one cycle output latency); load at edge N gives new glyph from edge N+1.
REQ-018 en low SHALL force seg_n and dig_n all ones; scan, blink counters and stage_q continue running.
REQ-019 load with stage /= stage_q SHALL restart the scan counter and digit index at 0 and, if blink enabled, arm blink.
REQ-020 load with stage = stage_q SHALL change no state.
REQ-021 Simultaneous load and frame end: the load action SHALL take priority; the frame-end update is discarded.

Reset
REQ-022 Reset asserted SHALL immediately set stage_q = 0, scan counter = 0, digit index = 0, blink count = 0, phase = 0, seg_n = 1111111, dig_n = all ones.
REQ-023 After reset release, first non-blank drive SHALL appear one edge later, showing stage 0 on digit 0.
REQ-024 Reset mid-blink or mid-scan SHALL abort all activity with no residual blink.

Configuration
REQ-025 Macro LAVAGEM_BLINK_EN defined: arming SHALL set blink count = BLINK_FRAMES and phase = blank.
- At each frame end with count > 0: count decrements, phase toggles.
- Blank phase forces seg_n = 1111111, dig_n still scans.
- Re-arm mid-blink restarts from BLINK_FRAMES.
REQ-026 Macro LAVAGEM_BLINK_EN undefined: no blink logic SHALL be present and the display SHALL be always steady; BLINK_FRAMES is ignored.

Verification (NUM_DIGITS=4, SCAN_DIV=4, BLINK_FRAMES=2)
REQ-027 Release reset, en=1 -> dig_n=1110, seg_n=0001001 for 4 cycles, then dig_n=1101, seg_n=0001001, then 1011/1111111, then 0111/1111111, then wrap.
REQ-028 load=1, stage=3, blink off -> next edge: dig_n=1110, seg_n=1101010; the following digit shows 1110001.
REQ-029 Blink on, load stage=5 -> frame 1 seg_n all ones, frame 2 shows 1001111/0110000, steady from frame 3.
REQ-030 load stage=5 mid-blink of frame 2 (same stage) -> blink continues unchanged; load stage=6 -> blink restarts, scan index 0.
REQ-031 en=0 for 10 cycles mid-scan -> outputs all ones; on en=1, digit index reflects 10 elapsed cycles.
REQ-032 Assert reset mid-blink, any clock phase -> outputs all ones immediately; after release, stage 0 steady, no blank frame.
